datapath_alu: RTL and testbench
===============================

# datapath_alu

Execution datapath driven by the 16-bit control word from the sequencing FSM: register file, A/B operand multiplexers, 3-bit-opcode ALU and result register. Each cycle it decodes the control word fields `[15:13]` cnt_alu, `[12:9]` slc_mux_a, `[8:5]` slc_mux_b, `[4:1]` slc_reg and `[0]` w. A side load port preloads operands; a debug read port exposes the register file to the bench.

## Interface
- WIDTH, 8, data width of registers, operands and result (minimum 2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_ctrl  in  16  control word: [15:13] alu op, [12:9] sel A, [8:5] sel B, [4:1] dest reg, [0] write enable
- i_ld_en  in  1  external load strobe
- i_ld_addr  in  4  external load register index
- i_ld_data  in  WIDTH  external load value
- i_rd_addr  in  4  debug read index
- o_rd_data  out  WIDTH  combinational RF[i_rd_addr]
- o_a  out  WIDTH  operand A register
- o_b  out  WIDTH  operand B register
- o_result  out  WIDTH  ALU result register Y
- o_carry  out  1  registered carry (ADD) / borrow (SUB), 0 for other ops
- o_zero  out  1  registered, Y == 0
- o_neg  out  1  registered, Y[WIDTH-1]

## Operation
- Register file: 16 x WIDTH, R0..R15. All entries are general purpose; R0 is writable.
- Operand stage, every cycle: A <= RF[i_ctrl[12:9]], B <= RF[i_ctrl[8:5]].
- ALU stage, every cycle: Y and flags <= f(A, B, i_ctrl[15:13]), using the A/B register values before this edge.
- Opcodes:
  - 000 ADD A+B, carry = bit WIDTH of the (WIDTH+1)-bit sum
  - 001 SUB A-B, carry = borrow (1 when A<B unsigned)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 pass A
  - 111 pass B
- Results wrap modulo 2^WIDTH.
- Write-back: when i_ctrl[0]=1, RF[i_ctrl[4:1]] <= Y, using the Y value before this edge (registered result, not the in-flight ALU output).
- External load: when i_ld_en=1, RF[i_ld_addr] <= i_ld_data.
- Collision on the same address with both write sources active: the external load wins and the write-back is dropped. Different addresses: both are written.
- No bypass. An operand read of the register being written in the same cycle returns the old value; the new value is visible one cycle later.
- Intended 5-cycle add sequence (controller states s0..s4):
  - 0x0000
  - 0x0000, latch A=R0
  - 0x0020, latch B=R1
  - 0x0020, Y=R0+R1
  - 0x0005, RF[R2] <= Y
- Reset: RF all zero. A, B, Y, o_carry, o_neg = 0; o_zero = 1. Reset is asynchronous: outputs change immediately on rst rising, independent of clk. Reset mid-sequence discards all in-flight values.

## Timing
- Operand latency: 1 cycle from i_ctrl select to o_a/o_b.
- Result latency: 2 cycles from i_ctrl select to o_result. The op field is sampled with the second edge, i.e. it applies to operands latched one cycle earlier.
- Write-back takes effect at the edge where w=1. The new value appears on o_rd_data immediately after that edge and in o_a/o_b one edge later.
- External load: 1 cycle, same visibility rules as write-back.
- First edge after rst deassertion performs normal operand/ALU updates; no dead cycle.
- No handshake; every cycle is valid. Undefined opcodes do not exist (all 8 encoded).

## Test plan
- Reset with random inputs toggling:
  - all outputs 0 except o_zero=1
  - RF[0..15] read back 0 via o_rd_data
- Controller add sequence, WIDTH=8:
  - preload R0=0x25, R1=0x13 via load port, then drive 0x0000, 0x0000, 0x0020, 0x0020, 0x0005
  - after last edge: RF[2]=0x38, o_result=0x38, o_carry=0
- Wrap and flags:
  - R0=0xF0, R1=0x20, ADD into R3 -> Y=0x10, carry=1, zero=0
  - SUB R1-R0 -> Y=0x30, carry(borrow)=1, neg=0
  - SUB R0-R0 -> Y=0x00, zero=1
- Opcode sweep with A=0xC5, B=0x3A:
  - ops 010..111 -> 0x00, 0xFF, 0xFF, 0x3A, 0xC5, 0x3A
  - o_neg matches bit 7 of each
- Collision and no-bypass:
  - w=1 dest=R4 with Y=0x11 while load R4=0x99 -> RF[4]=0x99
  - same-cycle sel A=R4 during a write to R4 -> o_a holds the old value, new value appears the next cycle
- Reset mid-operation:
  - assert rst between the 0x0020 and 0x0005 words -> RF[2] stays 0 and Y=0
  - after release, rerun the full sequence -> correct sum (R0/R1 reloaded)

Source files
------------

// File: rtl/datapath_alu.sv
`timescale 1ns/1ps
// datapath_alu: register file, operand registers A/B, 3-bit-opcode ALU and
// registered result/flags, all driven by a 16-bit control word each cycle.
// A side load port writes the register file and a debug port reads it back.
module datapath_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_ctrl,
  input  logic             i_ld_en,
  input  logic [3:0]       i_ld_addr,
  input  logic [WIDTH-1:0] i_ld_data,
  input  logic [3:0]       i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_neg
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOTA  = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_t;

  // Control word fields
  alu_op_t    w_op;
  logic [3:0] w_sel_a;
  logic [3:0] w_sel_b;
  logic [3:0] w_dest;
  logic       w_we;
  logic       w_wb_en;

  assign w_op    = alu_op_t'(i_ctrl[15:13]);
  assign w_sel_a = i_ctrl[12:9];
  assign w_sel_b = i_ctrl[8:5];
  assign w_dest  = i_ctrl[4:1];
  assign w_we    = i_ctrl[0];

  // The external load owns the port on an address collision; write-back is dropped.
  assign w_wb_en = w_we && !(i_ld_en && (i_ld_addr == w_dest));

  // Pipeline state
  logic [WIDTH-1:0] r_rf [16];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic             r_zero;
  logic             r_neg;

  // ALU combinational results
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_y;
  logic             w_c;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  // ALU function over the latched operands; the top bit of the extended difference is the borrow
  always_comb begin
    w_y = '0;
    w_c = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_y = w_sum[WIDTH-1:0];
        w_c = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_y = w_diff[WIDTH-1:0];
        w_c = w_diff[WIDTH];
      end
      OP_AND:   w_y = r_a & r_b;
      OP_OR:    w_y = r_a | r_b;
      OP_XOR:   w_y = r_a ^ r_b;
      OP_NOTA:  w_y = ~r_a;
      OP_PASSA: w_y = r_a;
      OP_PASSB: w_y = r_b;
    endcase
  end

  // Register file: write-back of the registered result and the external load, no bypass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (w_wb_en) begin
        r_rf[w_dest] <= r_y;
      end
      if (i_ld_en) begin
        r_rf[i_ld_addr] <= i_ld_data;
      end
    end
  end

  // Operand stage latches the selected registers every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= r_rf[w_sel_a];
      r_b <= r_rf[w_sel_b];
    end
  end

  // Result stage registers Y and its flags; an empty result after reset reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y     <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
      r_neg   <= 1'b0;
    end else begin
      r_y     <= w_y;
      r_carry <= w_c;
      r_zero  <= (w_y == '0);
      r_neg   <= w_y[WIDTH-1];
    end
  end

  assign o_rd_data = r_rf[i_rd_addr];
  assign o_a       = r_a;
  assign o_b       = r_b;
  assign o_result  = r_y;
  assign o_carry   = r_carry;
  assign o_zero    = r_zero;
  assign o_neg     = r_neg;

endmodule

// File: tb/tb_datapath_alu.sv
`timescale 1ns/1ps
// tb_datapath_alu: directed and random stimulus against a cycle-level
// arithmetic model of the register file, operand and result stages.
module tb_datapath_alu;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      ctrl = '0;
  logic             ldEn = 1'b0;
  logic [3:0]       ldAddr = '0;
  logic [WIDTH-1:0] ldData = '0;
  logic [3:0]       rdAddr = '0;
  logic [WIDTH-1:0] rdData;
  logic [WIDTH-1:0] outA;
  logic [WIDTH-1:0] outB;
  logic [WIDTH-1:0] outResult;
  logic             outCarry;
  logic             outZero;
  logic             outNeg;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [WIDTH-1:0] mRf [16];
  logic [WIDTH-1:0] mA, mB, mY;
  logic             mC, mZ, mN;

  datapath_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_ctrl    (ctrl),
    .i_ld_en   (ldEn),
    .i_ld_addr (ldAddr),
    .i_ld_data (ldData),
    .i_rd_addr (rdAddr),
    .o_rd_data (rdData),
    .o_a       (outA),
    .o_b       (outB),
    .o_result  (outResult),
    .o_carry   (outCarry),
    .o_zero    (outZero),
    .o_neg     (outNeg)
  );

  always #5 clk = ~clk;

  task automatic resetModel();
    for (int i = 0; i < 16; i++) mRf[i] = '0;
    mA = '0; mB = '0; mY = '0;
    mC = 1'b0; mZ = 1'b1; mN = 1'b0;
  endtask

  // One clock edge of the datapath, computed with plain integer arithmetic
  task automatic modelStep(input logic [15:0] c, input logic le, input logic [3:0] la,
                           input logic [WIDTH-1:0] ld);
    int a, b, r;
    int nC;
    logic [WIDTH-1:0] nA, nB;
    a = int'(mA);
    b = int'(mB);
    nC = 0;
    case (int'(c[15:13]))
      0: begin r = a + b; nC = (r >= 256) ? 1 : 0; end
      1: begin r = a - b; nC = (r < 0) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = a;
      default: r = b;
    endcase
    r = (r + 256) % 256;
    nA = mRf[int'(c[12:9])];
    nB = mRf[int'(c[8:5])];
    if (c[0]) mRf[int'(c[4:1])] = mY;
    if (le) mRf[int'(la)] = ld;
    mA = nA;
    mB = nB;
    mY = WIDTH'(r);
    mC = (nC != 0);
    mZ = (r == 0);
    mN = (r >= 128);
  endtask

  task automatic checkVal(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".a"},      outA,             mA);
    checkVal({tag, ".b"},      outB,             mB);
    checkVal({tag, ".result"}, outResult,        mY);
    checkVal({tag, ".carry"},  {7'b0, outCarry}, {7'b0, mC});
    checkVal({tag, ".zero"},   {7'b0, outZero},  {7'b0, mZ});
    checkVal({tag, ".neg"},    {7'b0, outNeg},   {7'b0, mN});
  endtask

  task automatic checkRf(input string tag, input logic [3:0] addr);
    rdAddr = addr;
    #1;
    checkVal(tag, rdData, mRf[int'(addr)]);
  endtask

  task automatic checkRfConst(input string tag, input logic [3:0] addr,
                              input logic [WIDTH-1:0] exp);
    rdAddr = addr;
    #1;
    checkVal(tag, rdData, exp);
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge
  task automatic applyStimulus(input logic [15:0] c, input logic le, input logic [3:0] la,
                               input logic [WIDTH-1:0] ld);
    @(negedge clk);
    rst = 1'b0;
    ctrl = c; ldEn = le; ldAddr = la; ldData = ld;
    @(posedge clk);
    modelStep(c, le, la, ld);
    #1;
  endtask

  task automatic loadReg(input logic [3:0] addr, input logic [WIDTH-1:0] data);
    applyStimulus(16'h0000, 1'b1, addr, data);
  endtask

  task automatic addSequence();
    applyStimulus(16'h0000, 1'b0, 4'd0, 8'h00);
    applyStimulus(16'h0000, 1'b0, 4'd0, 8'h00);
    applyStimulus(16'h0020, 1'b0, 4'd0, 8'h00);
    applyStimulus(16'h0020, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic asyncReset(input string tag);
    #1;
    rst = 1'b1;
    resetModel();
    #1;
    checkOutput(tag);
  endtask

  logic [WIDTH-1:0] sweepExp [6];

  initial begin
    sweepExp[0] = 8'h00; sweepExp[1] = 8'hFF; sweepExp[2] = 8'hFF;
    sweepExp[3] = 8'h3A; sweepExp[4] = 8'hC5; sweepExp[5] = 8'h3A;
    resetModel();

    // Reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctrl = 16'($urandom); ldEn = 1'b1; ldAddr = 4'($urandom); ldData = 8'($urandom);
      @(posedge clk);
      #1;
      checkOutput("reset");
    end
    ldEn = 1'b0;
    for (int i = 0; i < 16; i++) checkRfConst("reset_rf", 4'(i), 8'h00);

    // Controller add sequence
    loadReg(4'd0, 8'h25);
    loadReg(4'd1, 8'h13);
    addSequence();
    applyStimulus(16'h0005, 1'b0, 4'd0, 8'h00);
    checkOutput("add_seq");
    checkVal("add_result", outResult, 8'h38);
    checkVal("add_carry", {7'b0, outCarry}, 8'h00);
    checkRfConst("add_rf2", 4'd2, 8'h38);

    // Wrap and flags
    loadReg(4'd0, 8'hF0);
    loadReg(4'd1, 8'h20);
    applyStimulus(16'h0020, 1'b0, 4'd0, 8'h00);
    applyStimulus(16'h0020, 1'b0, 4'd0, 8'h00);
    checkOutput("wrap_add");
    checkVal("wrap_add_y", outResult, 8'h10);
    checkVal("wrap_add_c", {7'b0, outCarry}, 8'h01);
    checkVal("wrap_add_z", {7'b0, outZero}, 8'h00);
    applyStimulus(16'h0027, 1'b0, 4'd0, 8'h00);
    checkRfConst("wrap_rf3", 4'd3, 8'h10);
    applyStimulus(16'h2200, 1'b0, 4'd0, 8'h00);
    applyStimulus(16'h2200, 1'b0, 4'd0, 8'h00);
    checkOutput("sub_r1_r0");
    checkVal("sub_y", outResult, 8'h30);
    checkVal("sub_borrow", {7'b0, outCarry}, 8'h01);
    checkVal("sub_neg", {7'b0, outNeg}, 8'h00);
    applyStimulus(16'h2000, 1'b0, 4'd0, 8'h00);
    applyStimulus(16'h2000, 1'b0, 4'd0, 8'h00);
    checkOutput("sub_r0_r0");
    checkVal("sub_zero_y", outResult, 8'h00);
    checkVal("sub_zero_z", {7'b0, outZero}, 8'h01);

    // Opcode sweep with A=0xC5, B=0x3A
    loadReg(4'd5, 8'hC5);
    loadReg(4'd6, 8'h3A);
    applyStimulus(16'h0AC0, 1'b0, 4'd0, 8'h00);
    for (int op = 2; op < 8; op++) begin
      applyStimulus(16'(op << 13) | 16'h0AC0, 1'b0, 4'd0, 8'h00);
      checkOutput("sweep");
      checkVal("sweep_y", outResult, sweepExp[op - 2]);
      checkVal("sweep_neg", {7'b0, outNeg}, {7'b0, sweepExp[op - 2][7]});
    end

    // Collision: load wins; different addresses both land
    loadReg(4'd7, 8'h11);
    applyStimulus(16'hCE00, 1'b0, 4'd0, 8'h00);
    applyStimulus(16'hCE00, 1'b0, 4'd0, 8'h00);
    checkVal("coll_y", outResult, 8'h11);
    applyStimulus(16'hCE09, 1'b1, 4'd4, 8'h99);
    checkRfConst("coll_rf4", 4'd4, 8'h99);
    applyStimulus(16'hCE11, 1'b1, 4'd9, 8'h55);
    checkRfConst("dual_rf8", 4'd8, 8'h11);
    checkRfConst("dual_rf9", 4'd9, 8'h55);

    // No bypass: reading R4 while it is written
    applyStimulus(16'hC809, 1'b0, 4'd0, 8'h00);
    checkVal("nobypass_old", outA, 8'h99);
    checkRfConst("nobypass_rf4", 4'd4, 8'h11);
    applyStimulus(16'hC800, 1'b0, 4'd0, 8'h00);
    checkVal("nobypass_new", outA, 8'h11);
    checkOutput("nobypass");

    // Reset in the middle of the add sequence, then rerun
    loadReg(4'd0, 8'h25);
    loadReg(4'd1, 8'h13);
    addSequence();
    asyncReset("mid_reset");
    checkVal("mid_reset_y", outResult, 8'h00);
    applyStimulus(16'h0005, 1'b0, 4'd0, 8'h00);
    checkRfConst("mid_reset_rf2", 4'd2, 8'h00);
    loadReg(4'd0, 8'h25);
    loadReg(4'd1, 8'h13);
    addSequence();
    applyStimulus(16'h0005, 1'b0, 4'd0, 8'h00);
    checkVal("rerun_result", outResult, 8'h38);
    checkRfConst("rerun_rf2", 4'd2, 8'h38);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      applyStimulus(16'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom), 8'($urandom));
      checkOutput("rand");
      checkRf("rand_rf", 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
